// File: rtl/mod_pkg.sv
// Shared types and constants for the streaming modular accumulator.
package mod_pkg;

    localparam int unsigned DEF_BITWIDTH = 32;
    localparam int unsigned DEF_CNTW     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } accStateT;

    // Longest frame a CNTW-bit length field can describe.
    function automatic int unsigned maxLen(input int unsigned cntw);
        return (32'd1 << cntw) - 32'd1;
    endfunction

endpackage

// File: rtl/mod_if.sv
// Operand stream in, frame result out, plus control and status of mod_acc.
interface mod_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned CNTW     = 8
) ();

    logic                iEn;
    logic                iClr;
    logic [BITWIDTH-1:0] iQ;
    logic [CNTW-1:0]     iLen;
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH-1:0] oData;
    logic [CNTW-1:0]     oCount;
    logic                oBusy;

    modport master (
        output iEn, iClr, iQ, iLen, iValid, iData, iReady,
        input  oReady, oValid, oData, oCount, oBusy
    );

    modport slave (
        input  iEn, iClr, iQ, iLen, iValid, iData, iReady,
        output oReady, oValid, oData, oCount, oBusy
    );

endinterface

// File: rtl/mod_adder.sv
// Combinational (a + b) mod q for a, b < q; one extra sum bit absorbs the carry.
module mod_adder #(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic [BITWIDTH-1:0] iQ,
    output logic [BITWIDTH-1:0] oSum_c
);

    localparam int unsigned SW = BITWIDTH + 1;

    logic [SW-1:0] sumWide;
    logic [SW-1:0] qWide;

    always_comb begin
        sumWide = SW'(iA) + SW'(iB);
        qWide   = SW'(iQ);
        oSum_c  = (sumWide >= qWide) ? BITWIDTH'(sumWide - qWide) : BITWIDTH'(sumWide);
    end

endmodule

// File: rtl/mod_acc.sv
// Streaming modular accumulator: sums iLen operands mod iQ, one result per frame.
module mod_acc
    import mod_pkg::*;
#(
    parameter int unsigned BITWIDTH = DEF_BITWIDTH,
    parameter int unsigned CNTW     = DEF_CNTW
) (
    input  logic iClk,
    input  logic iRstN,
    mod_if.slave bus
);

    accStateT state, stateNext;

    logic [BITWIDTH-1:0] acc, accNext;
    logic [BITWIDTH-1:0] qReg, qNext;
    logic [CNTW-1:0]     lenReg, lenNext;
    logic [CNTW-1:0]     cnt, cntNext;
    logic                oValidReg, oBusyReg;

    logic [BITWIDTH-1:0] addA, addQ, addSum;
    logic [CNTW-1:0]     effLen, cntInc;
    logic                ready, accept;

    // Reset gating keeps oReady low while the block is held in reset.
    assign ready  = iRstN & bus.iEn & ~bus.iClr & (state != OUT);
    assign accept = bus.iValid & ready;
    assign effLen = (bus.iLen == '0) ? CNTW'(1) : bus.iLen;
    assign cntInc = CNTW'(cnt + CNTW'(1));

    // First beat adds to zero under the incoming modulus; later beats use the latched one.
    assign addA = (state == IDLE) ? '0     : acc;
    assign addQ = (state == IDLE) ? bus.iQ : qReg;

    mod_adder #(
        .BITWIDTH (BITWIDTH)
    ) uAdder (
        .iA     (addA),
        .iB     (bus.iData),
        .iQ     (addQ),
        .oSum_c (addSum)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accNext   = acc;
        qNext     = qReg;
        lenNext   = lenReg;
        cntNext   = cnt;
        if (bus.iClr) begin
            stateNext = IDLE;
            accNext   = '0;
            cntNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        qNext     = bus.iQ;
                        lenNext   = effLen;
                        accNext   = addSum;
                        cntNext   = CNTW'(1);
                        stateNext = (effLen == CNTW'(1)) ? OUT : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        accNext = addSum;
                        cntNext = cntInc;
                        if (cntInc == lenReg) begin
                            stateNext = OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.iReady) begin
                        stateNext = IDLE;
                        accNext   = '0;
                        cntNext   = '0;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    accNext   = '0;
                    cntNext   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            acc       <= '0;
            qReg      <= '0;
            lenReg    <= '0;
            cnt       <= '0;
            oValidReg <= 1'b0;
            oBusyReg  <= 1'b0;
        end else begin
            acc       <= accNext;
            qReg      <= qNext;
            lenReg    <= lenNext;
            cnt       <= cntNext;
            oValidReg <= (stateNext == OUT);
            oBusyReg  <= (stateNext != IDLE);
        end
    end

    assign bus.oReady = ready;
    assign bus.oValid = oValidReg;
    assign bus.oBusy  = oBusyReg;
    assign bus.oData  = acc;
    assign bus.oCount = cnt;

endmodule
